// File: rtl/matmul_accumulator_seq_pkg.sv
// rtl/matmul_accumulator_seq_pkg.sv - shared types, widths and clamp helper for the tile MAC accumulator
package matmul_pkg;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

    localparam int P_DEF  = 8;
    localparam int PROD_W = 2 * P_DEF;
    localparam int SUM_W  = 64;

    // Clamp a full-precision sum into the signed range of 'width' bits
    function automatic logic signed [SUM_W-1:0] sat_clamp(input logic signed [SUM_W-1:0] value,
                                                          input int width);
        logic signed [SUM_W-1:0] lo;
        logic signed [SUM_W-1:0] hi;
        lo = -(64'sd1 <<< (width - 1));
        hi = ~lo;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/matmul_accumulator_seq_if.sv
// rtl/matmul_accumulator_seq_if.sv - operand/result handshake bundle of the tile MAC accumulator
interface matmul_accumulator_seq_if #(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int K     = 4,
    parameter int P     = 8,
    parameter int ACC_W = 4 * P
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [P-1:0]     A [M][K];
    logic signed [P-1:0]     B [K][N];
    logic signed [ACC_W-1:0] C [M][N];
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] D [M][N];
    logic                    busy;

    modport master (output in_valid, A, B, C, out_ready,
                    input  in_ready, out_valid, D, busy);
    modport slave  (input  in_valid, A, B, C, out_ready,
                    output in_ready, out_valid, D, busy);
endinterface

// File: rtl/matmul_accumulator_seq_mac_tile_comb.sv
// rtl/matmul_accumulator_seq_mac_tile_comb.sv - combinational M*N dot products added to acc_in (SATURATE_EN clamps)
module mac_tile_comb
    import matmul_pkg::*;
#(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int K     = 4,
    parameter int P     = 8,
    parameter int PW    = PROD_W,
    parameter int ACC_W = 4 * P
) (
    input  logic signed [P-1:0]     A       [M][K],
    input  logic signed [P-1:0]     B       [K][N],
    input  logic signed [ACC_W-1:0] acc_in  [M][N],
    output logic signed [ACC_W-1:0] acc_out [M][N]
`ifdef SATURATE_EN
    ,
    output logic                    sat
`endif
);

    logic [PW-1:0]           ea;
    logic [PW-1:0]           eb;
    logic [PW-1:0]           prod;
    logic signed [SUM_W-1:0] sum;
`ifdef SATURATE_EN
    logic signed [SUM_W-1:0] clamped;
`endif

    // Per element: sign-extended K products plus the seed, summed at full precision, then narrowed
    always_comb begin
`ifdef SATURATE_EN
        sat     = 1'b0;
        clamped = '0;
`endif
        ea   = '0;
        eb   = '0;
        prod = '0;
        sum  = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                sum = {{(SUM_W-ACC_W){acc_in[i][j][ACC_W-1]}}, acc_in[i][j]};
                for (int k = 0; k < K; k++) begin
                    ea   = {{(PW-P){A[i][k][P-1]}}, A[i][k]};
                    eb   = {{(PW-P){B[k][j][P-1]}}, B[k][j]};
                    prod = ea * eb;
                    sum  = sum + {{(SUM_W-PW){prod[PW-1]}}, prod};
                end
`ifdef SATURATE_EN
                clamped       = sat_clamp(sum, ACC_W);
                acc_out[i][j] = clamped[ACC_W-1:0];
                if (clamped != sum) begin
                    sat = 1'b1;
                end
`else
                acc_out[i][j] = sum[ACC_W-1:0];
`endif
            end
        end
    end

endmodule

// File: rtl/matmul_accumulator_seq.sv
// rtl/matmul_accumulator_seq.sv - handshaked K_TILES-beat tile MAC accumulator (SATURATE_EN adds clamping and sat_flag)
module matmul_accumulator_seq
    import matmul_pkg::*;
#(
    parameter int M       = 4,
    parameter int N       = 4,
    parameter int K       = 4,
    parameter int P       = P_DEF,
    parameter int ACC_W   = 4 * P,
    parameter int K_TILES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    matmul_accumulator_seq_if.slave  bus
`ifdef SATURATE_EN
    ,
    output logic                     sat_flag
`endif
);

    localparam int            CW   = $clog2(K_TILES + 1);
    localparam logic [CW-1:0] LAST = CW'(K_TILES - 1);

    state_e                  state;
    state_e                  state_n;
    logic [CW-1:0]           cnt;
    logic                    beat;
    logic signed [ACC_W-1:0] acc     [M][N];
    logic signed [ACC_W-1:0] acc_in  [M][N];
    logic signed [ACC_W-1:0] acc_nxt [M][N];
`ifdef SATURATE_EN
    logic                    sat_now;
`endif

    // First beat of a run starts from C, later beats from the running sum
    always_comb begin
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                acc_in[i][j] = (state == IDLE) ? bus.C[i][j] : acc[i][j];
                bus.D[i][j]  = acc[i][j];
            end
        end
    end

    mac_tile_comb #(
        .M(M), .N(N), .K(K), .P(P), .PW(2 * P), .ACC_W(ACC_W)
    ) u_mac (
        .A       (bus.A),
        .B       (bus.B),
        .acc_in  (acc_in),
        .acc_out (acc_nxt)
`ifdef SATURATE_EN
        ,
        .sat     (sat_now)
`endif
    );

    // Next state and handshake outputs; outputs depend only on the registered state
    always_comb begin
        state_n       = state;
        bus.in_ready  = (state != OUT);
        bus.out_valid = (state == OUT);
        bus.busy      = (state != IDLE);
        beat          = bus.in_valid && (state != OUT);
        case (state)
            IDLE: if (beat) state_n = (K_TILES == 1) ? OUT : ACC;
            ACC:  if (beat && cnt == LAST) state_n = OUT;
            OUT:  if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Accumulator and beat counter; acc keeps the result after the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= '0;
                end
            end
        end else if (beat) begin
            cnt <= (state == IDLE) ? CW'(1) : cnt + CW'(1);
            acc <= acc_nxt;
        end else if (state == OUT && bus.out_ready) begin
            cnt <= '0;
        end
    end

`ifdef SATURATE_EN
    // Sticky clamp indicator for the current result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (beat && sat_now) begin
            sat_flag <= 1'b1;
        end else if (state == OUT && bus.out_ready) begin
            sat_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_accumulator_seq.sv
// tb/tb_matmul_accumulator_seq.sv - self-checking bench for matmul_accumulator_seq (SATURATE_EN aware)
module tb_matmul_accumulator_seq;
    import matmul_pkg::*;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int K  = 4;
    localparam int P  = 8;
    localparam int W1 = 16;
    localparam int W2 = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_accumulator_seq_if #(.M(M), .N(N), .K(K), .P(P), .ACC_W(W1)) bus1 ();
    matmul_accumulator_seq_if #(.M(M), .N(N), .K(K), .P(P), .ACC_W(W2)) bus2 ();
`ifdef SATURATE_EN
    logic sat1;
    logic sat2;
`endif

    matmul_accumulator_seq #(.M(M), .N(N), .K(K), .P(P), .ACC_W(W1), .K_TILES(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
`ifdef SATURATE_EN
        , .sat_flag(sat1)
`endif
    );

    matmul_accumulator_seq #(.M(M), .N(N), .K(K), .P(P), .ACC_W(W2), .K_TILES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
`ifdef SATURATE_EN
        , .sat_flag(sat2)
`endif
    );

    int     n_cmp = 0;
    int     n_err = 0;
    int     ta  [M][K];
    int     tbm [K][N];
    longint tc  [M][N];
    longint m_acc [M][N];
    bit     m_sat;
    int     m_beats;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference narrowing: wrap modulo 2^w, or clamp to the signed range when saturating
    function automatic longint fit(input longint v, input int w);
        longint span;
        longint hi;
        longint lo;
`ifndef SATURATE_EN
        longint r;
`endif
        span = longint'(1) << w;
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -hi - 1;
`ifdef SATURATE_EN
        if (v > hi) begin m_sat = 1'b1; return hi; end
        if (v < lo) begin m_sat = 1'b1; return lo; end
        return v;
`else
        r = v % span;
        if (r < 0) r += span;
        if (r > hi) r -= span;
        return r;
`endif
    endfunction

    // One accepted beat: D = (first ? C : D) + A x B, computed as a plain matrix product
    task automatic model_beat(input int w);
        longint dot;
        longint base;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                dot = 0;
                for (int k = 0; k < K; k++) dot += longint'(ta[i][k]) * longint'(tbm[k][j]);
                base = (m_beats == 0) ? tc[i][j] : m_acc[i][j];
                m_acc[i][j] = fit(base + dot, w);
            end
        end
        m_beats++;
    endtask

    task automatic set_const(input int a, input int b, input longint c);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                ta[i][j] = a; tbm[i][j] = b; tc[i][j] = c;
            end
    endtask

    task automatic randomize_ops(input int w);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                ta[i][j]  = int'($urandom_range(0, 255)) - 128;
                tbm[i][j] = int'($urandom_range(0, 255)) - 128;
                tc[i][j]  = (w == W1) ? longint'(int'($urandom_range(0, 65535)) - 32768)
                                      : longint'(int'($urandom));
            end
    endtask

    task automatic drive1();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                bus1.A[i][j] = P'(ta[i][j]);
                bus1.B[i][j] = P'(tbm[i][j]);
                bus1.C[i][j] = W1'(tc[i][j]);
            end
    endtask

    task automatic drive2();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                bus2.A[i][j] = P'(ta[i][j]);
                bus2.B[i][j] = P'(tbm[i][j]);
                bus2.C[i][j] = W2'(tc[i][j]);
            end
    endtask

    function automatic int d1_mismatches();
        int n = 0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                if (bus1.D[i][j] !== W1'(m_acc[i][j])) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat on dut1 until it is taken (bounded)
    task automatic beat1();
        bit rdy;
        bit taken = 1'b0;
        drive1();
        bus1.in_valid = 1'b1;
        for (int t = 0; t < 40 && !taken; t++) begin
            rdy = bus1.in_ready;
            step();
            taken = rdy;
        end
        bus1.in_valid = 1'b0;
        check("beat_accept", taken, 1);
        if (taken) model_beat(W1);
    endtask

    task automatic run1(input bit rnd, input int gmin, input int gmax, input bit chk_cnt);
        int g;
        m_beats = 0;
        for (int b = 0; b < 4; b++) begin
            if (rnd) randomize_ops(W1);
            if (b > 0) begin
                g = int'($urandom_range(gmin, gmax));
                repeat (g) begin
                    step();
                    if (chk_cnt) check("cnt_hold_gap", {61'd0, dut1.cnt}, m_beats);
                end
            end
            beat1();
            if (b < 3) check("no_early_valid", bus1.out_valid, 0);
        end
        check("valid_latency", bus1.out_valid, 1);
    endtask

    task automatic collect1(input int stall);
        int t = 0;
        while (!bus1.out_valid && t < 40) begin step(); t++; end
        check("result_wait", bus1.out_valid, 1);
        repeat (stall) begin
            step();
            check("stall_valid", bus1.out_valid, 1);
        end
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("D1[%0d][%0d]", i, j), bus1.D[i][j], m_acc[i][j]);
`ifdef SATURATE_EN
        check("sat_flag", sat1, m_sat);
`endif
        bus1.out_ready = 1'b1;
        step();
        bus1.out_ready = 1'b0;
        check("release_valid", bus1.out_valid, 0);
        m_sat = 1'b0;
`ifdef SATURATE_EN
        check("sat_cleared", sat1, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
        set_const(0, 0, 0);
        drive1();
        drive2();
        m_sat = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", bus1.out_valid, 0);
        check("rst_busy", bus1.busy, 0);
        check("rst_in_ready", bus1.in_ready, 1);
        m_acc = '{default: 0};
        check("rst_D_zero", d1_mismatches(), 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // 1: constant tiles, back-to-back beats
        set_const(1, 2, 10);
        run1(1'b0, 0, 0, 1'b0);
        check("t1_D_42", bus1.D[2][3], 42);
        collect1(0);

        // 2: three-cycle gaps between beats
        run1(1'b0, 3, 3, 1'b1);
        collect1(0);

        // 3: result held five cycles while a new beat is offered
        randomize_ops(W1);
        m_beats = 0;
        for (int b = 0; b < 4; b++) beat1();
        randomize_ops(W1);
        drive1();
        bus1.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t3_in_ready_low", bus1.in_ready, 0);
            check("t3_D_stable", d1_mismatches(), 0);
        end
        bus1.out_ready = 1'b1;
        m_sat = 1'b0;
        step();
        bus1.out_ready = 1'b0;
        check("t3_idle_after_release", bus1.busy, 0);
        check("t3_cnt_zero", {61'd0, dut1.cnt}, 0);
        m_beats = 0;
        step();
        bus1.in_valid = 1'b0;
        model_beat(W1);
        check("t3_first_beat_taken", {61'd0, dut1.cnt}, 1);
        for (int b = 1; b < 4; b++) beat1();
        collect1(0);

        // 4: asynchronous reset mid-run, then identity run
        randomize_ops(W1);
        m_beats = 0;
        beat1();
        beat1();
        rst_n = 1'b0;
        #1;
        check("t4_rst_busy", bus1.busy, 0);
        check("t4_rst_valid", bus1.out_valid, 0);
        check("t4_rst_cnt", {61'd0, dut1.cnt}, 0);
        m_acc = '{default: 0};
        check("t4_rst_D", d1_mismatches(), 0);
        step();
        rst_n = 1'b1;
        step();
        set_const(0, 0, 0);
        for (int i = 0; i < M; i++) begin ta[i][i] = 1; tbm[i][i] = 1; end
        run1(1'b0, 0, 1, 1'b0);
        check("t4_diag", bus1.D[1][1], 4);
        check("t4_offdiag", bus1.D[0][1], 0);
        collect1(0);

        // 5: -128 x -128 with C at the positive limit
        set_const(-128, -128, 32767);
        run1(1'b0, 0, 0, 1'b0);
        check("t5_D", bus1.D[3][0], 32767);
`ifdef SATURATE_EN
        check("t5_sat_set", sat1, 1);
`endif
        collect1(2);

        // Random runs with random gaps and output stalls
        for (int r = 0; r < 10; r++) begin
            run1(1'b1, 0, 2, 1'b0);
            collect1(int'($urandom_range(0, 3)));
        end

        // 6: single-beat configuration, C=-5 plus products summing to 3
        set_const(0, 1, -5);
        for (int i = 0; i < M; i++) for (int k = 0; k < 3; k++) ta[i][k] = 1;
        for (int r = 0; r < 6; r++) begin
            if (r > 0) randomize_ops(W2);
            drive2();
            m_beats = 0;
            m_sat = 1'b0;
            model_beat(W2);
            bus2.in_valid = 1'b1;
            check("t6_in_ready", bus2.in_ready, 1);
            step();
            bus2.in_valid = 1'b0;
            check("t6_valid_next", bus2.out_valid, 1);
            if (r == 0) check("t6_D_minus2", bus2.D[1][2], -2);
            nz = 0;
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++)
                    if (bus2.D[i][j] !== W2'(m_acc[i][j])) nz++;
            check("t6_D_all", nz, 0);
`ifdef SATURATE_EN
            check("t6_sat", sat2, m_sat);
`endif
            bus2.out_ready = 1'b1;
            step();
            bus2.out_ready = 1'b0;
            check("t6_release", bus2.out_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
